// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / scoreboard unit.
package fwd_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int SEL_RF = 0;

  typedef enum logic [1:0] {HZ_NONE, HZ_PENDING, HZ_BUSY, HZ_WAW} hz_cause_e;

endpackage

// File: rtl/fwd_sb_entry.sv
// One scoreboard slot: busy bit plus a countdown of remaining long-latency cycles.
module fwd_sb_entry
#(
  parameter int LAT_W = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set,
  input  logic [LAT_W-1:0] i_lat,
  output logic             o_busy
);

  logic             r_busy;
  logic [LAT_W-1:0] r_cnt;

  // A zero latency still occupies the slot for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_cnt  <= (i_lat == '0) ? LAT_W'(1) : i_lat;
    end else if (r_busy) begin
      if (r_cnt == LAT_W'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// EX-stage forwarding select + hazard stall with a long-latency scoreboard.
// Optional perf counters enabled by defining FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int NUM_FWD = 2,
  parameter  int REG_AW  = 5,
  parameter  int LAT_W   = 4,
  localparam int SEL_W   = clog2(NUM_FWD + 1),
  localparam int NREG    = 2 ** REG_AW
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_regwrite,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [NREG-1:0]           busy_vec
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);

  logic [NREG-1:0]    w_busy;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_bhz;
  logic               w_waw;
  logic               w_issue_acc;
  hz_cause_e          w_cause;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] w_rs;
    logic [SEL_W-1:0]  w_s;
    logic              w_p;

    assign w_rs = ex_rs[i*REG_AW +: REG_AW];

    // Scan oldest to nearest so the nearest matching stage has the last word.
    always_comb begin
      w_s = SEL_W'(SEL_RF);
      w_p = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_regwrite[k] && fwd_rd[k*REG_AW +: REG_AW] == w_rs) begin
          w_s = fwd_ready[k] ? SEL_W'(k + 1) : SEL_W'(SEL_RF);
          w_p = !fwd_ready[k];
        end
      end
      if (w_rs == '0) begin
        w_s = SEL_W'(SEL_RF);
        w_p = 1'b0;
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = w_s;
    assign w_pend[i] = w_p;
    assign w_bhz[i]  = (w_rs != '0) && w_busy[w_rs];
  end

  assign w_waw       = issue_valid && (issue_rd != '0) && w_busy[issue_rd];
  assign stall       = ex_valid && ((|w_pend) || (|w_bhz) || w_waw);
  assign w_issue_acc = issue_valid && !stall && (issue_rd != '0) && !reset;

  assign w_busy[0] = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_sb
    fwd_sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk    (clk),
      .reset  (reset),
      .i_set  (w_issue_acc && (issue_rd == REG_AW'(r))),
      .i_lat  (issue_lat),
      .o_busy (w_busy[r])
    );
  end

  assign busy_vec = w_busy;

  always_comb begin
    w_cause = HZ_NONE;
    if (|w_pend)     w_cause = HZ_PENDING;
    else if (|w_bhz) w_cause = HZ_BUSY;
    else if (w_waw)  w_cause = HZ_WAW;
  end

  a_stall_cause: assert property (@(posedge clk) disable iff (reset)
    stall |-> (w_cause != HZ_NONE));

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_fwd   <= '0;
    end else begin
      if (stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (ex_valid && !stall && (|fwd_sel) && r_perf_fwd != '1)
        r_perf_fwd <= r_perf_fwd + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_fwd_cnt   = r_perf_fwd;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit with a per-register remaining-cycles model.
module tb_fwd_scoreboard_unit;

  localparam int NS = 2, NF = 2, AW = 5, LW = 4, SW = 2, NR = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             ex_valid;
  logic [NS*AW-1:0] ex_rs;
  logic [NF*AW-1:0] fwd_rd;
  logic [NF-1:0]    fwd_regwrite;
  logic [NF-1:0]    fwd_ready;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic [LW-1:0]    issue_lat;
  logic [NS*SW-1:0] fwd_sel;
  logic             stall;
  logic [NR-1:0]    busy_vec;
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_fwd_cnt;
`endif

  fwd_scoreboard_unit #(.NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW), .LAT_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_rs        (ex_rs),
    .fwd_rd       (fwd_rd),
    .fwd_regwrite (fwd_regwrite),
    .fwd_ready    (fwd_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .busy_vec     (busy_vec)
`ifdef FWD_SCOREBOARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int m_rem [NR];
  longint m_pstall = 0;
  longint m_pfwd   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Nearest writing stage decides; an unready nearest match blocks older ones.
  function automatic int m_sel(input int rs, output bit pend);
    pend = 1'b0;
    if (rs == 0) return 0;
    for (int k = 1; k <= NF; k++) begin
      if (fwd_regwrite[k-1] && int'(fwd_rd[(k-1)*AW +: AW]) == rs) begin
        if (fwd_ready[k-1]) return k;
        pend = 1'b1;
        return 0;
      end
    end
    return 0;
  endfunction

  function automatic logic [NS*SW-1:0] m_selvec();
    logic [NS*SW-1:0] v;
    bit p;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(m_sel(int'(ex_rs[i*AW +: AW]), p));
    return v;
  endfunction

  function automatic bit m_stall();
    bit p, hz;
    int rs, s;
    hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      rs = int'(ex_rs[i*AW +: AW]);
      s = m_sel(rs, p);
      if (p || (rs != 0 && m_rem[rs] > 0)) hz = 1'b1;
    end
    if (issue_valid && issue_rd != 0 && m_rem[issue_rd] > 0) hz = 1'b1;
    return ex_valid && hz;
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] b;
    for (int r = 0; r < NR; r++) b[r] = (m_rem[r] > 0);
    return b;
  endfunction

  always @(posedge clk) begin
    bit st, acc;
    if (reset) begin
      foreach (m_rem[r]) m_rem[r] = 0;
      m_pstall = 0;
      m_pfwd   = 0;
    end else begin
      st  = m_stall();
      acc = issue_valid && !st && issue_rd != 0;
      if (st && m_pstall < 64'hFFFF_FFFF) m_pstall++;
      if (ex_valid && !st && m_selvec() != 0 && m_pfwd < 64'hFFFF_FFFF) m_pfwd++;
      foreach (m_rem[r]) if (m_rem[r] > 0) m_rem[r]--;
      if (acc) m_rem[issue_rd] = (issue_lat == 0) ? 1 : int'(issue_lat);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_fwd_sel", 64'(fwd_sel), 64'(m_selvec()));
      chk("cmp_stall", 64'(stall), 64'(m_stall()));
      chk("cmp_busy_vec", 64'(busy_vec), 64'(m_busy()));
`ifdef FWD_SCOREBOARD_PERF_EN
      chk("cmp_perf_stall", 64'(perf_stall_cnt), 64'(m_pstall));
      chk("cmp_perf_fwd", 64'(perf_fwd_cnt), 64'(m_pfwd));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_rs = '0; fwd_rd = '0; fwd_regwrite = '0; fwd_ready = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
  endtask

  task automatic set_rs(input int i, input int v);
    ex_rs[i*AW +: AW] = AW'(v);
  endtask

  task automatic set_fwd(input int k, input int rd, input bit we, input bit rdy);
    fwd_rd[(k-1)*AW +: AW] = AW'(rd);
    fwd_regwrite[k-1] = we;
    fwd_ready[k-1] = rdy;
  endtask

  task automatic issue(input int rd, input int lat);
    issue_valid = 1'b1;
    issue_rd = AW'(rd);
    issue_lat = LW'(lat);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    cyc();

    // both stages match: nearest wins
    ex_valid = 1'b1; set_rs(0, 5); set_fwd(1, 5, 1, 1); set_fwd(2, 5, 1, 1);
    settle();
    chk("t1_sel0", 64'(fwd_sel[SW-1:0]), 64'd1);
    chk("t1_stall", 64'(stall), 64'd0);
    cyc();

    set_fwd(1, 5, 1, 0);
    settle();
    chk("t2_sel0_pend", 64'(fwd_sel[SW-1:0]), 64'd0);
    chk("t2_stall_pend", 64'(stall), 64'd1);
    cyc();
    set_fwd(1, 0, 0, 0);
    settle();
    chk("t2_sel0_wb", 64'(fwd_sel[SW-1:0]), 64'd2);
    chk("t2_stall_wb", 64'(stall), 64'd0);
    cyc();

    idle(); ex_valid = 1'b1; set_rs(0, 3); set_rs(1, 0); set_fwd(1, 0, 1, 1); set_fwd(2, 3, 1, 1);
    settle();
    chk("t3_sel1_r0", 64'(fwd_sel[2*SW-1:SW]), 64'd0);
    chk("t3_sel0", 64'(fwd_sel[SW-1:0]), 64'd2);
    chk("t3_stall", 64'(stall), 64'd0);
    cyc();

    // long-latency issue rd7 lat3, then WAW on the expiring cycle
    idle(); ex_valid = 1'b1; issue(7, 3);
    settle();
    chk("t4_acc_stall", 64'(stall), 64'd0);
    cyc();
    issue_valid = 1'b0; set_rs(1, 7);
    settle();
    chk("t4_busy7_c1", 64'(busy_vec[7]), 64'd1);
    chk("t4_busy_stall", 64'(stall), 64'd1);
    cyc();
    set_rs(1, 0);
    settle();
    chk("t4_busy7_c2", 64'(busy_vec[7]), 64'd1);
    cyc();
    issue(7, 2);
    settle();
    chk("t4_busy7_c3", 64'(busy_vec[7]), 64'd1);
    chk("t4_waw_stall", 64'(stall), 64'd1);
    cyc();
    settle();
    chk("t4_busy7_c4", 64'(busy_vec[7]), 64'd0);
    chk("t4_waw_clear", 64'(stall), 64'd0);
    cyc();
    issue(9, 0);
    settle();
    chk("t4_reissue7", 64'(busy_vec[7]), 64'd1);
    chk("t4_par_stall", 64'(stall), 64'd0);
    cyc();
    issue_valid = 1'b0;
    settle();
    chk("t4_busy9_lat0", 64'(busy_vec[9]), 64'd1);
    cyc();
    settle();
    chk("t4_busy9_done", 64'(busy_vec[9]), 64'd0);
    chk("t4_busy7_done", 64'(busy_vec[7]), 64'd0);
    cyc();

    // mid-count reset discards the entry and ignores issue while high
    issue(12, 8);
    settle();
    chk("t5_acc_stall", 64'(stall), 64'd0);
    cyc();
    issue_valid = 1'b0;
    settle();
    chk("t5_busy12", 64'(busy_vec[12]), 64'd1);
    cyc();
    reset = 1'b1; issue(14, 3);
    settle();
    chk("t5_busy12_inrst", 64'(busy_vec[12]), 64'd1);
    cyc();
    reset = 1'b0; issue_valid = 1'b0; set_rs(0, 12);
    settle();
    chk("t5_busy_vec_rst", 64'(busy_vec), 64'd0);
    chk("t5_stall_rst", 64'(stall), 64'd0);
`ifdef FWD_SCOREBOARD_PERF_EN
    chk("t5_perf_stall0", 64'(perf_stall_cnt), 64'd0);
    chk("t5_perf_fwd0", 64'(perf_fwd_cnt), 64'd0);
`endif
    cyc();

    idle();
    for (int i = 0; i < 4; i++) cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
